// File: rtl/gf_clmul_seq.sv
// Sequential carry-less (GF(2) polynomial) multiplier: one shift-and-XOR step per cycle.
// Optional macro GF_CLMUL_EARLY_EXIT_EN ends the iteration once the multiplier is exhausted.
module gf_clmul_seq #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [DATA_WIDTH-1:0]           op_a,
   input  logic [DATA_WIDTH-1:0]           op_b,
   input  logic [$clog2(DATA_WIDTH):0]     polyn_grade_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [2*DATA_WIDTH-1:0]         reduc_in,
   output logic [$clog2(DATA_WIDTH):0]     polyn_grade,
   output logic                            busy
);

   localparam int GW = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                    state, state_nxt;
   logic [2*DATA_WIDTH-1:0]   a_q;
   logic [2*DATA_WIDTH-1:0]   acc_q;
   logic [DATA_WIDTH-1:0]     b_q;
   logic [GW-1:0]             cnt_q;
   logic [GW-1:0]             grade_q;
   logic                      run_end;
   logic                      accept;
   logic                      release_out;

   // run_end is evaluated after the iteration that completes the product,
   // so the RUN->DONE transition costs one extra edge beyond the iterations.
   always_comb begin
`ifdef GF_CLMUL_EARLY_EXIT_EN
      run_end = (cnt_q == GW'(DATA_WIDTH)) || ((cnt_q != '0) && (b_q == '0));
`else
      run_end = (cnt_q == GW'(DATA_WIDTH));
`endif
   end

   assign accept      = (state == IDLE) && in_valid;
   assign release_out = (state == DONE) && out_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)      state_nxt = RUN;
         RUN:     if (run_end)     state_nxt = DONE;
         DONE:    if (release_out) state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         grade_q <= '0;
      end else if (accept) begin
         a_q     <= {{DATA_WIDTH{1'b0}}, op_a};
         b_q     <= op_b;
         acc_q   <= '0;
         cnt_q   <= '0;
         grade_q <= polyn_grade_in;
      end else if ((state == RUN) && !run_end) begin
         if (b_q[0]) acc_q <= acc_q ^ a_q;
         a_q   <= a_q << 1;
         b_q   <= b_q >> 1;
         cnt_q <= cnt_q + GW'(1);
      end
   end

   assign in_ready    = (state == IDLE);
   assign out_valid   = (state == DONE);
   assign busy        = (state != IDLE);
   assign reduc_in    = acc_q;
   assign polyn_grade = grade_q;

endmodule

// File: tb/tb_gf_clmul_seq.sv
// Self-checking bench for gf_clmul_seq (DATA_WIDTH=64): directed and random products
// compared with a bitwise carry-less multiply model, plus latency, hold and reset checks.
module tb_gf_clmul_seq;

   localparam int W  = 64;
   localparam int GW = $clog2(W) + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic [GW-1:0]   polyn_grade_in;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  reduc_in;
   logic [GW-1:0]   polyn_grade;
   logic            busy;

   int tests = 0;
   int fails = 0;

   gf_clmul_seq #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .polyn_grade_in(polyn_grade_in),
      .out_valid(out_valid), .out_ready(out_ready), .reduc_in(reduc_in),
      .polyn_grade(polyn_grade), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] r = '0;
      for (int i = 0; i < W; i++)
         if (b[i]) r = r ^ ({{W{1'b0}}, a} << i);
      return r;
   endfunction

   function automatic int exp_latency(input logic [W-1:0] b);
`ifdef GF_CLMUL_EARLY_EXIT_EN
      int top = 0;
      for (int i = 0; i < W; i++) if (b[i]) top = i;
      return top + 2;
`else
      return W + 1;
`endif
   endfunction

   task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [GW-1:0] g, input int hold);
      logic [2*W-1:0] exp;
      int n;
      exp = clmul(a, b);
      check("in_ready_idle", {127'b0, in_ready}, 128'd1);
      op_a = a; op_b = b; polyn_grade_in = g; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op_a = rnd64(); op_b = rnd64(); polyn_grade_in = GW'($urandom_range(0, W));
      check("busy_run", {127'b0, busy}, 128'd1);
      check("in_ready_run", {127'b0, in_ready}, 128'd0);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!out_valid && n < 200);
      check("latency", 128'(n), 128'(exp_latency(b)));
      check("product", reduc_in, exp);
      check("msb_zero", {127'b0, reduc_in[2*W-1]}, 128'd0);
      check("grade", 128'(polyn_grade), 128'(g));
      for (int k = 0; k < hold; k++) begin
         in_valid = k[0];
         op_a = rnd64(); op_b = rnd64();
         @(posedge clk); #1;
         check("hold_product", reduc_in, exp);
         check("hold_valid", {127'b0, out_valid}, 128'd1);
         check("hold_in_ready", {127'b0, in_ready}, 128'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_valid", {127'b0, out_valid}, 128'd0);
      check("post_in_ready", {127'b0, in_ready}, 128'd1);
      check("post_busy", {127'b0, busy}, 128'd0);
   endtask

   initial begin
      int seen;
      logic [W-1:0] ra, rb;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op_a = '0; op_b = '0; polyn_grade_in = '0;
      #2;
      check("rst_in_ready", {127'b0, in_ready}, 128'd1);
      check("rst_out_valid", {127'b0, out_valid}, 128'd0);
      check("rst_busy", {127'b0, busy}, 128'd0);
      check("rst_product", reduc_in, 128'd0);
      check("rst_grade", 128'(polyn_grade), 128'd0);
      #10 rst = 1'b0;

      run_op(64'h9, 64'hA, GW'(4), 0);
      run_op(64'h7, 64'h3, GW'(7), 2);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, GW'(64), 0);
      run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, GW'(63), 0);
      run_op(64'h0, rnd64(), GW'(5), 0);
      run_op(rnd64(), 64'h0, GW'(6), 0);
      run_op(64'h1234, 64'h5678, GW'(16), 10);
      for (int t = 0; t < 8; t++) begin
         ra = rnd64(); rb = rnd64();
         if (t[0]) rb = rb >> $urandom_range(0, 63);
         run_op(ra, rb, GW'($urandom_range(0, W)), int'($urandom_range(0, 3)));
      end

      // Abort an operation part way through RUN.
      op_a = 64'hDEAD_BEEF; op_b = 64'hFFFF_FFFF_FFFF_FFFF; polyn_grade_in = GW'(9);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (30) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("abort_in_ready", {127'b0, in_ready}, 128'd1);
      check("abort_out_valid", {127'b0, out_valid}, 128'd0);
      check("abort_busy", {127'b0, busy}, 128'd0);
      check("abort_product", reduc_in, 128'd0);
      check("abort_grade", 128'(polyn_grade), 128'd0);
      #3 rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 80; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("abort_no_output", 128'(seen), 128'd0);
      run_op(64'h3, 64'h3, GW'(2), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gf_clmul_seq.md
GF_CLMUL_SEQ -- requirements
Module: gf_clmul_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, operand width in bits (GF(2) polynomial coefficients).
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block accepts operands.
REQ-006 SHALL have port op_a  input  DATA_WIDTH  multiplicand polynomial.
REQ-007 SHALL have port op_b  input  DATA_WIDTH  multiplier polynomial.
REQ-008 SHALL have port polyn_grade_in  input  $clog2(DATA_WIDTH)+1  field degree, carried with operands.
REQ-009 SHALL have port out_valid  output  1  product available.
REQ-010 SHALL have port out_ready  input  1  downstream reduction stage accepts product.
REQ-011 SHALL have port reduc_in  output  2*DATA_WIDTH  carry-less product, feeds reduction stage reduc_in.
REQ-012 SHALL have port polyn_grade  output  $clog2(DATA_WIDTH)+1  degree captured with the operands.
REQ-013 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready capture op_a zero-extended to 2*DATA_WIDTH into shift reg A, op_b into shift reg B, polyn_grade_in, clear accumulator and iteration counter, go to RUN.
REQ-016 RUN, each cycle: if B[0] accumulator ^= A; A <<= 1; B >>= 1; counter += 1; pure XOR arithmetic, no carries.
REQ-017 RUN SHALL exit to DONE after exactly DATA_WIDTH iterations; out_valid rises DATA_WIDTH+1 edges after the accepting edge.
REQ-018 DONE: out_valid=1, reduc_in=accumulator and polyn_grade held stable until out_valid&&out_ready, then go to IDLE.
REQ-019 in_ready SHALL be 0 in RUN and DONE; in_valid ignored there; op_a/op_b changes after capture have no effect.
REQ-020 out_ready SHALL be ignored outside DONE; out_ready held low keeps DONE indefinitely with outputs unchanged.
REQ-021 Product bit 2*DATA_WIDTH-1 SHALL always be 0; no bits lost at A shift (A width 2*DATA_WIDTH).
REQ-022 Zero operand SHALL still take full latency and yield reduc_in=0.
REQ-023 Back-to-back: earliest next acceptance is the edge after the output handshake (one IDLE cycle).

Reset
REQ-024 rst high SHALL asynchronously force IDLE, in_ready=1, out_valid=0, busy=0, reduc_in=0, polyn_grade=0, counter=0.
REQ-025 rst asserted mid-RUN or in DONE SHALL abort the operation; no out_valid for it after release.
REQ-026 First acceptance allowed on the first rising edge with rst low.

Configuration
REQ-027 Macro GF_CLMUL_EARLY_EXIT_EN defined: RUN SHALL exit to DONE at the end of any iteration after which B==0 (minimum 1 iteration), so latency = index of highest set bit of op_b + 1 iterations (1 if op_b=0).
REQ-028 Macro undefined: fixed DATA_WIDTH-iteration latency per REQ-017; products identical in both builds.

Verification (DATA_WIDTH=64)
REQ-029 op_a=0x9, op_b=0xA, grade 4 -> reduc_in=90 (0x5A), polyn_grade=4, out_valid 65 edges after acceptance.
REQ-030 op_a=0x7, op_b=0x3 -> reduc_in=0x9; op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=0x1 -> reduc_in=0x0000_..._FFFF_FFFF_FFFF_FFFF.
REQ-031 op_a=op_b=0x8000_0000_0000_0000 -> reduc_in bit 126 only set, bit 127 = 0.
REQ-032 out_ready low 10 cycles in DONE -> reduc_in stable, in_ready=0, in_valid pulses ignored; out_ready high -> IDLE next edge.
REQ-033 rst pulse at iteration 30 -> all outputs at reset values immediately; new op 0x3x0x3 after release -> reduc_in=0x5.
REQ-034 With GF_CLMUL_EARLY_EXIT_EN: op_b=0x1 -> out_valid 2 edges after acceptance; op_b=0x0 -> reduc_in=0 after 1 iteration.
